time_set_controller: RTL and testbench
======================================

# time_set_controller

Sequencer for the clock's time register: turns three raw push-buttons into the register's 2-bit mode select and a single enable strobe. In normal running it issues the 1 Hz seconds tick; while a set button is held it switches the register into the matching set mode and issues auto-repeat increments. Sits between the board button inputs and the time register in the clock top level.

## Interface
- SYS_CLK_HZ, 50_000_000, i_clk frequency; seconds prescaler period in cycles
- FAST_SET_HZ, 5, auto-repeat rate while a set button is held; period = SYS_CLK_HZ/FAST_SET_HZ cycles (integer division, must be ≥ 2)
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required to accept a button level change
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high; one clock domain
- i_set_minutes  in  1  raw button, active-high, asynchronous to i_clk
- i_set_hours  in  1  raw button, active-high, asynchronous to i_clk
- i_clear_seconds  in  1  raw button, active-high, asynchronous to i_clk
- o_mode  out  2  time register mode: 0 COUNTING, 1 SET_MINUTES, 2 SET_HOURS, 3 CLEAR_SECONDS
- o_en  out  1  single-cycle enable strobe to the time register

## Operation
- Each button: 2-flop synchronizer, then debouncer; debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- FSM states RUN, SET_MIN, SET_HR, CLR_SEC; o_mode is the registered state encoding (RUN=0, SET_MIN=1, SET_HR=2, CLR_SEC=3).
- RUN: on any debounced button high, go to CLR_SEC / SET_HR / SET_MIN with priority clear > hours > minutes.
- Set states are locked: other buttons ignored; return to RUN only when all three debounced levels are low.
- Seconds prescaler: counts 0..SYS_CLK_HZ-1, free-running; wrap generates the seconds tick. o_en = seconds tick only in RUN and outside the guard window.
- SET_MIN/SET_HR: one entry strobe, then one strobe per fast-prescaler wrap while held. Fast prescaler counts 0..SYS_CLK_HZ/FAST_SET_HZ-1, cleared on entry to any set state.
- CLR_SEC: exactly one strobe (entry strobe), no repeats; seconds prescaler held at 0 while in CLR_SEC so the first second after release is a full period.
- Simultaneous raw presses resolve by priority only after each debounces; whichever debounced level goes high first wins.

## Timing
- Reset values: o_mode=0, o_en=0, state RUN, both prescalers 0, synchronizers and debounced levels 0.
- Button-to-state latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- State change visible on o_mode at cycle N (first cycle of new state). Entry strobe at cycle N+2. Cycles N and N+1 are a guard window: o_en=0 regardless of ticks. Same 2-cycle guard applies on return to RUN (seconds tick falling in it is dropped).
- First auto-repeat strobe: N+2+SYS_CLK_HZ/FAST_SET_HZ... exactly one fast period after the entry strobe; subsequent strobes every fast period.
- o_en never high for two consecutive cycles.
- Release during a set state: no strobe in the cycle the state leaves; a pending repeat is discarded.
- Asynchronous reset mid-operation: all outputs to reset values immediately; buttons still held must re-debounce before re-entering a set state.

## Structure
- Shared package clock_pkg: mode constants MODE_COUNTING, MODE_SET_MINUTES, MODE_SET_HOURS, MODE_CLEAR_SECONDS (2-bit); same constants used by the time register.
- Sub-module button_debounce (synchronizer + stability counter, parameter DEBOUNCE_CYCLES), instantiated three times.
- Prescalers, guard counter and FSM live in time_set_controller.

## Test plan
(SYS_CLK_HZ=20, FAST_SET_HZ=4, DEBOUNCE_CYCLES=3)
- Reset, no buttons for 100 cycles -> o_mode=0, o_en pulses exactly at cycles 19, 39, 59, 79, 99 after reset release.
- Hold i_set_minutes 40 cycles -> o_mode=1 at 6 cycles after press; o_en at +2 from mode change, then every 5 cycles; o_mode=0 ~6 cycles after release, no strobe in guard.
- Hold i_clear_seconds 30 cycles -> o_mode=3, exactly one o_en; after return to RUN, next seconds strobe 20 cycles after CLR_SEC exit.
- i_set_hours and i_set_minutes raised same cycle -> o_mode=2; releasing only hours keeps o_mode=2 until minutes released.
- Bounce: i_set_hours toggling every 2 cycles for 20 cycles -> o_mode stays 0, no extra o_en.
- Assert i_reset mid SET_HR with button held -> o_mode=0, o_en=0 asynchronously; re-enters SET_HR 6 cycles after reset release.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: time register mode encodings shared by the set controller and the time register
package clock_pkg;
  localparam logic [1:0] MODE_COUNTING      = 2'd0;
  localparam logic [1:0] MODE_SET_MINUTES   = 2'd1;
  localparam logic [1:0] MODE_SET_HOURS     = 2'd2;
  localparam logic [1:0] MODE_CLEAR_SECONDS = 2'd3;
  typedef enum logic [1:0] {
    RUN     = MODE_COUNTING,
    SET_MIN = MODE_SET_MINUTES,
    SET_HR  = MODE_SET_HOURS,
    CLR_SEC = MODE_CLEAR_SECONDS
  } state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer plus stability counter for one raw push-button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      cnt  <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
      if (sync[1] != level && done) level <= sync[1];
    end
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: turns set buttons into time register mode select and enable strobes
module time_set_controller import clock_pkg::*; #(
  parameter int SYS_CLK_HZ      = 50_000_000,
  parameter int FAST_SET_HZ     = 5,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_set_minutes,
  input  logic       i_set_hours,
  input  logic       i_clear_seconds,
  output logic [1:0] o_mode,
  output logic       o_en
);
  localparam int FAST_P = SYS_CLK_HZ / FAST_SET_HZ;
  localparam int SW = $clog2(SYS_CLK_HZ);
  localparam int FW = $clog2(FAST_P);
  logic [2:0] raw, lvl;
  state_t state, next_state;
  logic [1:0] guard;
  logic [SW-1:0] sec_cnt;
  logic [FW-1:0] fast_cnt;
  logic sec_tick, fast_tick, change;
  assign raw = {i_clear_seconds, i_set_hours, i_set_minutes};
  for (genvar b = 0; b < 3; b++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(i_clk), .rst(i_reset), .button(raw[b]), .level(lvl[b])
    );
  end
  assign sec_tick  = sec_cnt == SW'(SYS_CLK_HZ - 1);
  assign fast_tick = fast_cnt == FW'(FAST_P - 1);
  assign change    = next_state != state;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= RUN;
    else state <= next_state;
  always_comb
    next_state = state == RUN ? (lvl[2] ? CLR_SEC : lvl[1] ? SET_HR : lvl[0] ? SET_MIN : RUN)
                              : (|lvl ? state : RUN);
  // guard runs 3,2 (blanked), 1 (entry strobe slot), 0; fast prescaler restarts once it expires
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      guard    <= '0;
      sec_cnt  <= '0;
      fast_cnt <= '0;
    end else begin
      guard    <= change ? 2'd3 : guard != 2'd0 ? guard - 2'd1 : 2'd0;
      sec_cnt  <= (state == CLR_SEC || sec_tick) ? '0 : sec_cnt + 1'b1;
      fast_cnt <= (change || guard != 2'd0 || fast_tick) ? '0 : fast_cnt + 1'b1;
    end
  always_comb begin
    o_mode = state;
    o_en   = !guard[1] && !(change && state != RUN) &&
             (state == RUN ? sec_tick : guard == 2'd1 || (state != CLR_SEC && guard == 2'd0 && fast_tick));
  end
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: randomized and scenario checks against a cycle-delta reference model
module tb_time_set_controller;
  localparam int SYS = 20;
  localparam int FS  = 4;
  localparam int DC  = 3;
  localparam int FP  = SYS / FS;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_set_minutes = 1'b0, i_set_hours = 1'b0, i_clear_seconds = 1'b0;
  logic [1:0] o_mode;
  logic o_en;
  int passed = 0, total = 0;
  int t, mode_m, n_entry, origin;
  logic [2:0] lvl;
  logic [2:0] raw_h [0:4095];
  logic [1:0] exp_mode;
  logic exp_en;

  time_set_controller #(.SYS_CLK_HZ(SYS), .FAST_SET_HZ(FS), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_set_minutes(i_set_minutes), .i_set_hours(i_set_hours),
    .i_clear_seconds(i_clear_seconds), .o_mode(o_mode), .o_en(o_en)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] raw_at(input int i);
    return i < 0 ? 3'b000 : raw_h[i];
  endfunction

  // Model: a debounced level flips once the raw level seen 3..DC+2 cycles ago all disagreed with it;
  // strobes are placed by distance from the last mode change and from the seconds origin.
  task automatic model_step();
    int d, nxt;
    logic [2:0] r;
    logic flip;
    for (int i = 0; i < 3; i++) begin
      flip = 1'b1;
      for (int k = 3; k < 3 + DC; k++) begin
        r = raw_at(t - k);
        if (r[i] == lvl[i]) flip = 1'b0;
      end
      if (flip) lvl[i] = ~lvl[i];
    end
    d = t - n_entry;
    if (mode_m == 0) nxt = lvl[2] ? 3 : lvl[1] ? 2 : lvl[0] ? 1 : 0;
    else nxt = (lvl != 3'b000) ? mode_m : 0;
    exp_mode = 2'(mode_m);
    if (d < 2) exp_en = 1'b0;
    else if (mode_m == 0) exp_en = ((t - origin) % SYS) == SYS - 1;
    else if (nxt != mode_m) exp_en = 1'b0;
    else if (mode_m == 3) exp_en = d == 2;
    else exp_en = ((d - 2) % FP) == 0;
    if (nxt != mode_m) begin
      n_entry = t + 1;
      if (mode_m == 3) origin = t + 1;
      mode_m = nxt;
    end
  endtask

  task automatic drive(input logic [2:0] b);
    {i_clear_seconds, i_set_hours, i_set_minutes} = b;
    raw_h[t] = b;
  endtask

  task automatic tick(input logic [2:0] b);
    @(posedge clk);
    #1;
    t++;
    model_step();
    drive(b);
  endtask

  task automatic release_reset(input logic [2:0] b);
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    t = 0; mode_m = 0; n_entry = -100; origin = 0; lvl = 3'b000;
    model_step();
    drive(b);
  endtask

  task automatic test_reset();
    int n = 0;
    release_reset(3'b000);
    total++;
    if (o_mode !== 2'd0 || o_en !== 1'b0) $display("FAIL reset_state mode=%0d en=%0b expected mode=0 en=0", o_mode, o_en);
    else passed++;
    while (t < 99) begin
      tick(3'b000);
      total++;
      if (o_mode !== 2'd0 || o_en !== (t % SYS == SYS - 1))
        $display("FAIL idle_seconds t=%0d mode=%0d en=%0b expected mode=0 en=%0b", t, o_mode, o_en, t % SYS == SYS - 1);
      else passed++;
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL idle_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      n += int'(o_en);
    end
    total++;
    if (n !== 5) $display("FAIL idle_strobe_count got=%0d expected=5", n);
    else passed++;
  endtask

  task automatic test_set_minutes();
    int p, entry = -1, leave = -1, n = 0;
    repeat (7) tick(3'b000);
    p = t + 1;
    for (int c = 0; c < 60; c++) begin
      tick(c < 40 ? 3'b001 : 3'b000);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL set_minutes_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (o_mode == 2'd1 && entry < 0) entry = t;
      if (o_mode == 2'd1) n += int'(o_en);
      if (entry >= 0 && leave < 0 && o_mode == 2'd0) leave = t;
    end
    total++;
    if (entry - p !== 6) $display("FAIL set_minutes_entry latency=%0d expected=6", entry - p);
    else passed++;
    total++;
    if (n !== 8) $display("FAIL set_minutes_strobes got=%0d expected=8", n);
    else passed++;
    total++;
    if (leave - (p + 40) !== 6) $display("FAIL set_minutes_exit latency=%0d expected=6", leave - (p + 40));
    else passed++;
  endtask

  task automatic test_clear_seconds();
    int p, entry = -1, leave = -1, ft = -1, n = 0;
    repeat (10) tick(3'b000);
    p = t + 1;
    for (int c = 0; c < 80; c++) begin
      tick(c < 30 ? 3'b100 : 3'b000);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL clear_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (o_mode == 2'd3 && entry < 0) entry = t;
      if (o_mode == 2'd3) n += int'(o_en);
      if (entry >= 0 && leave < 0 && o_mode == 2'd0) leave = t;
      if (leave >= 0 && ft < 0 && o_en === 1'b1) ft = t;
    end
    total++;
    if (entry - p !== 6) $display("FAIL clear_entry latency=%0d expected=6", entry - p);
    else passed++;
    total++;
    if (n !== 1) $display("FAIL clear_strobes got=%0d expected=1", n);
    else passed++;
    total++;
    if (ft - (leave - 1) !== 20) $display("FAIL clear_first_second got=%0d expected=20", ft - (leave - 1));
    else passed++;
  endtask

  task automatic test_priority();
    int p, first = -1, mid = -1, leave = -1;
    repeat (10) tick(3'b000);
    p = t + 1;
    for (int c = 0; c < 60; c++) begin
      tick(c < 15 ? 3'b011 : c < 35 ? 3'b001 : 3'b000);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL priority_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (first < 0 && o_mode != 2'd0) first = int'(o_mode);
      if (c == 30) mid = int'(o_mode);
      if (first >= 0 && leave < 0 && o_mode == 2'd0) leave = t;
    end
    total++;
    if (first !== 2) $display("FAIL priority_first_mode got=%0d expected=2", first);
    else passed++;
    total++;
    if (mid !== 2) $display("FAIL priority_locked got=%0d expected=2", mid);
    else passed++;
    total++;
    if (leave - p !== 41) $display("FAIL priority_exit got=%0d expected=41", leave - p);
    else passed++;
  endtask

  task automatic test_bounce();
    int moved = 0;
    repeat (10) tick(3'b000);
    for (int c = 0; c < 40; c++) begin
      tick((c < 20 && (c / 2) % 2 == 0) ? 3'b010 : 3'b000);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL bounce_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (o_mode != 2'd0) moved++;
    end
    total++;
    if (moved !== 0) $display("FAIL bounce_mode cycles_not_counting=%0d expected=0", moved);
    else passed++;
  endtask

  task automatic test_async_reset();
    int p, entry = -1;
    repeat (10) tick(3'b000);
    p = t + 1;
    for (int c = 0; c < 9; c++) begin
      tick(3'b010);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL pre_reset_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (o_mode == 2'd2 && entry < 0) entry = t;
    end
    total++;
    if (entry - p !== 6) $display("FAIL hours_entry latency=%0d expected=6", entry - p);
    else passed++;
    #3 i_reset = 1'b1;
    #1;
    total++;
    if (o_mode !== 2'd0 || o_en !== 1'b0) $display("FAIL async_reset mode=%0d en=%0b expected mode=0 en=0", o_mode, o_en);
    else passed++;
    release_reset(3'b010);
    entry = -1;
    for (int c = 0; c < 40; c++) begin
      tick(c < 20 ? 3'b010 : 3'b000);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL post_reset_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      if (o_mode == 2'd2 && entry < 0) entry = t;
    end
    total++;
    if (entry !== 6) $display("FAIL reentry latency=%0d expected=6", entry);
    else passed++;
  endtask

  task automatic test_random();
    logic [2:0] b = 3'b000;
    logic prev = 1'b0;
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        b = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) b = 3'b000;
        hold = $urandom_range(1, 30);
      end
      hold--;
      tick(b);
      total++;
      if (o_mode !== exp_mode || o_en !== exp_en)
        $display("FAIL random_model t=%0d mode=%0d en=%0b expected mode=%0d en=%0b", t, o_mode, o_en, exp_mode, exp_en);
      else passed++;
      total++;
      if (prev && o_en) $display("FAIL back_to_back t=%0d en=1 expected en=0 after strobe", t);
      else passed++;
      prev = o_en;
    end
  endtask

  initial begin
    test_reset();
    test_set_minutes();
    test_clear_seconds();
    test_priority();
    test_bounce();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
